// File: rtl/noc_endp_link_pkg.sv
// noc_endp_link_pkg: flit field offsets, one-hot check and LAT bound for noc_endp_link
package noc_endp_link_pkg;
  localparam int LAT_MAX = 3;
  function automatic int head_bit(input int fpay, input int v);
    return fpay + v + 1;
  endfunction
  function automatic int tail_bit(input int fpay, input int v);
    return fpay + v;
  endfunction
  function automatic int vc_lsb(input int fpay, input int v);
    return fpay + 0 * v;
  endfunction
  function automatic int vc_msb(input int fpay, input int v);
    return fpay + v - 1;
  endfunction
  function automatic logic is_onehot(input logic [31:0] x);
    return (x != 32'd0) && ((x & (x - 32'd1)) == 32'd0);
  endfunction
endpackage

// File: rtl/noc_endp_link_pipe.sv
// noc_endp_link_pipe: WIDTH x DEPTH shift register, DEPTH=0 is a plain wire
module noc_endp_link_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  if (DEPTH == 0) begin : g_wire
    logic w_unused;
    assign w_unused = i_clk ^ i_rst_n;
    assign o_q = i_d;
  end else begin : g_reg
    logic [WIDTH-1:0] r_q [DEPTH];
    always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
        for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
      end else begin
        r_q[0] <= i_d;
        for (int i = 1; i < DEPTH; i++) r_q[i] <= r_q[i-1];
      end
    assign o_q = r_q[DEPTH-1];
  end
endmodule

// File: rtl/noc_endp_link.sv
// noc_endp_link: LAT-stage flit/credit link between NIs and noc endpoints.
// Define NOC_ENDP_LINK_MON_EN to compile in the per-endpoint, per-VC credit monitor.
module noc_endp_link
  import noc_endp_link_pkg::*;
#(
  parameter int NE   = 4,
  parameter int V    = 2,
  parameter int Fpay = 32,
  parameter int Fw   = Fpay + V + 2,
  parameter int B    = 4,
  parameter int LAT  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NE*Fw-1:0] tile_flit_out_all,
  input  logic [NE-1:0]    tile_flit_out_wr_all,
  input  logic [NE*V-1:0]  tile_credit_out_all,
  output logic [NE*Fw-1:0] tile_flit_in_all,
  output logic [NE-1:0]    tile_flit_in_wr_all,
  output logic [NE*V-1:0]  tile_credit_in_all,
  output logic [NE*Fw-1:0] noc_flit_in_all,
  output logic [NE-1:0]    noc_flit_in_wr_all,
  output logic [NE*V-1:0]  noc_credit_in_all,
  input  logic [NE*Fw-1:0] noc_flit_out_all,
  input  logic [NE-1:0]    noc_flit_out_wr_all,
  input  logic [NE*V-1:0]  noc_credit_out_all,
  output logic [NE-1:0]    err_ovf,
  output logic [NE-1:0]    err_crd,
  output logic [NE-1:0]    err_vc,
  input  logic             err_clr
);
  localparam int PW = NE * (Fw + 1 + V);
  noc_endp_link_pipe #(.WIDTH(PW), .DEPTH(LAT)) u_inj (
    .i_clk(clk),
    .i_rst_n(reset),
    .i_d({tile_flit_out_all, tile_flit_out_wr_all, tile_credit_out_all}),
    .o_q({noc_flit_in_all, noc_flit_in_wr_all, noc_credit_in_all})
  );
  noc_endp_link_pipe #(.WIDTH(PW), .DEPTH(LAT)) u_ej (
    .i_clk(clk),
    .i_rst_n(reset),
    .i_d({noc_flit_out_all, noc_flit_out_wr_all, noc_credit_out_all}),
    .o_q({tile_flit_in_all, tile_flit_in_wr_all, tile_credit_in_all})
  );
`ifdef NOC_ENDP_LINK_MON_EN
  localparam int CW = $clog2(B + 1);
  localparam int VL = vc_lsb(Fpay, V);
  for (genvar e = 0; e < NE; e++) begin : g_ep
    logic [V-1:0] w_vc, w_ovf, w_crd;
    logic w_wr, w_bad;
    logic r_ovf, r_crd, r_vce;
    assign w_vc  = tile_flit_out_all[e*Fw+VL +: V];
    assign w_wr  = tile_flit_out_wr_all[e];
    assign w_bad = w_wr & ~is_onehot(32'(w_vc));
    for (genvar v = 0; v < V; v++) begin : g_vc
      logic [CW-1:0] r_cnt;
      logic w_dec, w_inc;
      assign w_dec    = w_wr & ~w_bad & w_vc[v];
      // credits are counted where the NI sees them, after the ejection pipe
      assign w_inc    = tile_credit_in_all[e*V+v];
      assign w_ovf[v] = w_dec & ~w_inc & (r_cnt == '0);
      assign w_crd[v] = w_inc & ~w_dec & (r_cnt == CW'(B));
      always_ff @(posedge clk or negedge reset)
        if (!reset) r_cnt <= CW'(B);
        else if (w_dec & ~w_inc & (r_cnt != '0)) r_cnt <= r_cnt - CW'(1);
        else if (w_inc & ~w_dec & (r_cnt != CW'(B))) r_cnt <= r_cnt + CW'(1);
    end
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        r_ovf <= 1'b0;
        r_crd <= 1'b0;
        r_vce <= 1'b0;
      end else begin
        r_ovf <= (|w_ovf) | (r_ovf & ~err_clr);
        r_crd <= (|w_crd) | (r_crd & ~err_clr);
        r_vce <= w_bad | (r_vce & ~err_clr);
      end
    assign err_ovf[e] = r_ovf;
    assign err_crd[e] = r_crd;
    assign err_vc[e]  = r_vce;
  end
`else
  logic w_unused;
  assign w_unused = err_clr;
  assign err_ovf  = '0;
  assign err_crd  = '0;
  assign err_vc   = '0;
`endif
endmodule
